// File: rtl/lsu_pkg.sv
// Shared definitions for the sub-word load/store unit: funct3 codes,
// FSM state encoding and the byte-lane mask helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    // Byte lanes of a little-endian word touched by an access of the given
    // size at the given byte offset. Alignment is checked elsewhere.
    function automatic logic [3:0] lane_mask(input logic [2:0] funct3,
                                             input logic [1:0] offset);
        logic [3:0] mask;
        mask = 4'b0000;
        case (funct3)
            F3_B, F3_BU: mask = 4'b0001 << offset;
            F3_H, F3_HU: mask = offset[1] ? 4'b1100 : 4'b0011;
            F3_W:        mask = 4'b1111;
            default:     mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load path: picks the addressed byte/half out of the memory
// word and sign- or zero-extends it according to funct3.
module lsu_load_ext (
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);
    import lsu_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by extension; illegal funct3 yields zero.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path leaves it unassigned and infers a latch.
        load_data = '0;
        byte_sel  = 8'(rdata >> {offset, 3'b000});
        half_sel  = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            F3_W:    load_data = rdata;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_subword.sv
// Load/store unit in front of a word-only data memory. Loads and full-word
// stores complete in one cycle; byte/half stores are a two-cycle
// read-modify-write that stalls the core for the read cycle.
module lsu_subword #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic [XLEN-1:0]   load_data,
    output logic              stall,
    output logic              misaligned,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);
    import lsu_pkg::*;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [XLEN-1:0]   merged_q;

    logic              f3_legal, is_half, is_word;
    logic              req_eff, req_mis, req_ok, start_rmw;
    logic [ADDR_W-1:0] word_addr;
    logic [3:0]        mask;
    logic [XLEN-1:0]   wlanes, merged, ext_data;

    assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};

    // Request decode: legality, size and alignment of the incoming op.
    always_comb begin
        is_half  = (req_funct3 == F3_H) || (req_funct3 == F3_HU);
        is_word  = (req_funct3 == F3_W);
        // Stores only have B/H/W forms; the unsigned codes are load-only.
        if (req_we)
            f3_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) || is_word;
        else
            f3_legal = (req_funct3 == F3_B) || (req_funct3 == F3_BU) || is_half || is_word;
        req_eff = req_valid && f3_legal;
        req_mis = req_eff && ((is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00)));
        req_ok  = req_eff && !req_mis;
    end

    // Store merge: replicate the store data across lanes, then take the
    // masked lanes from it and the rest from the current memory word.
    always_comb begin
        mask   = lane_mask(req_funct3, req_addr[1:0]);
        wlanes = (req_funct3 == F3_B) ? {4{req_wdata[7:0]}} : {2{req_wdata[15:0]}};
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = mask[i] ? wlanes[8*i +: 8] : mem_rdata[8*i +: 8];
    end

    lsu_load_ext u_load_ext (
        .rdata     (mem_rdata),
        .offset    (req_addr[1:0]),
        .funct3    (req_funct3),
        .load_data (ext_data)
    );

    // Next-state and output decode; reset forces every output low, which
    // also abandons a pending RMW write.
    always_comb begin
        state_d    = state_q;
        start_rmw  = 1'b0;
        load_data  = '0;
        stall      = 1'b0;
        misaligned = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    misaligned = req_mis;
                    if (req_ok) begin
                        mem_addr = word_addr;
                        if (!req_we) begin
                            mem_read  = 1'b1;
                            load_data = ext_data;
                        end else if (is_word) begin
                            mem_write = 1'b1;
                            mem_wdata = req_wdata;
                        end else begin
                            mem_read  = 1'b1;
                            stall     = 1'b1;
                            start_rmw = 1'b1;
                            state_d   = RMW_WR;
                        end
                    end
                end
                RMW_WR: begin
                    mem_write = 1'b1;
                    mem_addr  = wr_addr_q;
                    mem_wdata = merged_q;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register plus the captured RMW address and merged word.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= IDLE;
            // NOTE: the RMW data registers are cleared too; they are only
            // consumed in RMW_WR, but a defined value keeps outputs clean.
            wr_addr_q <= '0;
            merged_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start_rmw) begin
                wr_addr_q <= word_addr;
                merged_q  <= merged;
            end
        end
    end

endmodule

// File: tb/tb_lsu_subword.sv
// Self-checking bench for lsu_subword: a word-only data memory model,
// a directed vector table, hand-written multi-cycle sequences and a
// randomized run checked against a byte-array reference model.
module tb_lsu_subword;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
    logic        stall, misaligned, mem_read, mem_write;

    lsu_subword #(.ADDR_W(32), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .load_data  (load_data),
        .stall      (stall),
        .misaligned (misaligned),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Word-only data memory: combinational read, write on the rising edge.
    logic [31:0] mem [0:63];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (pre_we)         mem[pre_idx] <= pre_data;
        else if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    end

    // Reference model: plain little-endian byte array.
    logic [7:0] ref_b [0:255];

    function automatic logic [31:0] ref_word(input int a);
        return {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
        logic [7:0]  b;
        logic [15:0] h;
        b = ref_b[a];
        h = {ref_b[(a+1) % 256], ref_b[a]};
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'h0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'h0, h};
            3'd2:    return ref_word(a);
            default: return 32'h0;
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] f3, input int a, input logic [31:0] d);
        int n;
        n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) ref_b[a+i] = d[8*i +: 8];
    endtask

    typedef enum {K_NONE, K_MIS, K_LOAD, K_SW, K_RMW} kind_t;

    function automatic kind_t classify(input bit valid, input bit we,
                                       input logic [2:0] f3, input int a);
        int size;
        bit legal;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!valid || !legal) return K_NONE;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (a % size != 0) return K_MIS;
        if (!we) return K_LOAD;
        return (size == 4) ? K_SW : K_RMW;
    endfunction

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // {mem_read, mem_write, stall, misaligned}
    function automatic logic [31:0] strobes();
        return {28'h0, mem_read, mem_write, stall, misaligned};
    endfunction

    // Drive one request and check every cycle it occupies.
    task automatic do_op(input string name, input bit valid, input bit we,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_load,
                         input logic [31:0] exp_wdata, input bit upd);
        kind_t k;
        k = classify(valid, we, f3, int'(addr[7:0]));
        req_valid = valid; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        case (k)
            K_NONE: begin
                check({name, "/strb"}, strobes(), 32'b0000);
                check({name, "/ld"}, load_data, 32'h0);
            end
            K_MIS: begin
                check({name, "/strb"}, strobes(), 32'b0001);
                check({name, "/ld"}, load_data, 32'h0);
            end
            K_LOAD: begin
                check({name, "/strb"}, strobes(), 32'b1000);
                check({name, "/addr"}, mem_addr, addr & ~32'h3);
                check({name, "/ld"}, load_data, exp_load);
            end
            K_SW: begin
                check({name, "/strb"}, strobes(), 32'b0100);
                check({name, "/addr"}, mem_addr, addr);
                check({name, "/wd"}, mem_wdata, exp_wdata);
            end
            default: begin
                check({name, "/c0strb"}, strobes(), 32'b1010);
                check({name, "/c0addr"}, mem_addr, addr & ~32'h3);
                @(negedge clk);
                check({name, "/c1strb"}, strobes(), 32'b0100);
                check({name, "/c1addr"}, mem_addr, addr & ~32'h3);
                check({name, "/c1wd"}, mem_wdata, exp_wdata);
            end
        endcase
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (upd && (k == K_SW || k == K_RMW)) ref_store(f3, int'(addr[7:0]), wdata);
    endtask

    typedef struct {
        string       name;
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_load;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input string n, input bit we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] el, input logic [31:0] ew);
        vec_t v;
        v.name = n; v.we = we; v.f3 = f3; v.addr = a; v.wdata = d;
        v.exp_load = el; v.exp_wdata = ew;
        vq.push_back(v);
    endtask

    initial begin
        logic [31:0] w, el, ew, a;
        logic [3:0]  hist;
        logic [2:0]  f3;
        bit          we, valid;
        kind_t       k;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = F3_W;
        req_addr = '0; req_wdata = '0; pre_we = 1'b0; pre_idx = '0; pre_data = '0;

        // Preload memory and reference with the same contents.
        for (int i = 0; i < 64; i++) begin
            w = (i == 4) ? 32'h112233C4 : $urandom;
            for (int j = 0; j < 4; j++) ref_b[4*i+j] = w[8*j +: 8];
            @(negedge clk);
            pre_we = 1'b1; pre_idx = 6'(i); pre_data = w;
        end
        @(negedge clk);
        pre_we = 1'b0;

        // Outputs held at zero while reset is asserted, even with a request.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h10;
        @(negedge clk);
        check("rst/strb", strobes(), 32'h0);
        check("rst/ld", load_data, 32'h0);
        check("rst/addr", mem_addr, 32'h0);
        req_we = 1'b1; req_funct3 = F3_B;
        @(negedge clk);
        check("rst/st_strb", strobes(), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("idle/strb", strobes(), 32'h0);
        @(posedge clk);
        #1;

        add_vec("lw10",   0, F3_W,  32'h10, 0,            32'h112233C4, 0);
        add_vec("lb10",   0, F3_B,  32'h10, 0,            32'hFFFFFFC4, 0);
        add_vec("lbu10",  0, F3_BU, 32'h10, 0,            32'h000000C4, 0);
        add_vec("lh12",   0, F3_H,  32'h12, 0,            32'h00001122, 0);
        add_vec("sb11",   1, F3_B,  32'h11, 32'h000000AB, 0, 32'h1122ABC4);
        add_vec("lw10b",  0, F3_W,  32'h10, 0,            32'h1122ABC4, 0);
        add_vec("sh12",   1, F3_H,  32'h12, 32'h0000BEEF, 0, 32'hBEEFABC4);
        add_vec("sw14",   1, F3_W,  32'h14, 32'hDEADBEEF, 0, 32'hDEADBEEF);
        add_vec("lw14",   0, F3_W,  32'h14, 0,            32'hDEADBEEF, 0);
        add_vec("lw06",   0, F3_W,  32'h06, 0,            0, 0);
        add_vec("lh13",   0, F3_H,  32'h13, 0,            0, 0);
        add_vec("sh13",   1, F3_H,  32'h13, 32'h00001234, 0, 0);
        add_vec("lw10c",  0, F3_W,  32'h10, 0,            32'hBEEFABC4, 0);
        add_vec("ill011", 0, 3'b011, 32'h10, 0,           0, 0);
        add_vec("lhu12",  0, F3_HU, 32'h12, 0,            32'h0000BEEF, 0);
        add_vec("lh12s",  0, F3_H,  32'h12, 0,            32'hFFFFBEEF, 0);

        foreach (vq[i])
            do_op(vq[i].name, 1'b1, vq[i].we, vq[i].f3, vq[i].addr, vq[i].wdata,
                  vq[i].exp_load, vq[i].exp_wdata, 1'b1);

        // Back-to-back byte stores: four cycles, stall 1,0,1,0.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B;
        req_addr = 32'h10; req_wdata = 32'h00000055;
        @(negedge clk); hist[3] = stall;
        @(negedge clk); hist[2] = stall;
        check("b2b/wd0", mem_wdata, 32'hBEEFAB55);
        @(posedge clk);
        #1 req_addr = 32'h13; req_wdata = 32'h00000066;
        @(negedge clk); hist[1] = stall;
        @(negedge clk); hist[0] = stall;
        check("b2b/wd1", mem_wdata, 32'h66EFAB55);
        check("b2b/stall", 32'(hist), 32'b1010);
        @(posedge clk);
        #1 req_valid = 1'b0;
        ref_store(F3_B, 'h10, 32'h55);
        ref_store(F3_B, 'h13, 32'h66);
        do_op("b2b/lw", 1, 0, F3_W, 32'h10, 0, 32'h66EFAB55, 0, 1'b1);

        // Reset in the write cycle abandons the store.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B;
        req_addr = 32'h10; req_wdata = 32'h00000077;
        @(negedge clk);
        check("rstrmw/c0strb", strobes(), 32'b1010);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rstrmw/strb", strobes(), 32'h0);
        check("rstrmw/wd", mem_wdata, 32'h0);
        check("rstrmw/addr", mem_addr, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0; req_valid = 1'b0;
        do_op("rstrmw/lw", 1, 0, F3_W, 32'h10, 0, 32'h66EFAB55, 0, 1'b1);

        // Randomized traffic against the byte-array model.
        for (int n = 0; n < 400; n++) begin
            valid = ($urandom_range(0, 9) != 0);
            we    = 1'($urandom_range(0, 1));
            f3    = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            a     = 32'($urandom_range(0, 255));
            w     = $urandom;
            k     = classify(valid, we, f3, int'(a));
            el    = (k == K_LOAD) ? ref_load(f3, int'(a)) : 32'h0;
            ew    = 32'h0;
            if (k == K_SW || k == K_RMW) begin
                ref_store(f3, int'(a), w);
                ew = ref_word(int'(a) & ~3);
            end
            do_op($sformatf("rnd%0d", n), valid, we, f3, a, w, el, ew, 1'b0);
        end

        // Final sweep: every memory word must match the model.
        for (int i = 0; i < 64; i++)
            do_op($sformatf("sweep%0d", i), 1, 0, F3_W, 32'(4*i), 0, ref_word(4*i), 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lsu_subword.md
Name: lsu_subword

Overview:
- Load/store unit sitting directly upstream of data_mem. It converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests from the core into word-wide data_mem accesses.
- data_mem is word-only: combinational read, write on posedge clk. Sub-word stores are therefore done as a 2-cycle read-modify-write, with a stall to the core.
- Loads are extracted and sign/zero-extended combinationally.
- Misaligned accesses are blocked and flagged.

Parameters:
- ADDR_W, 32, byte address width of req_addr and mem_addr.
- XLEN, 32, data width. Only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  core presents a memory op this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  XLEN  store data, right-aligned.
- load_data  output  XLEN  extended load result, combinational.
- stall  output  1  core must hold its request and PC this cycle.
- misaligned  output  1  access blocked due to alignment.
- mem_read  output  1  to data_mem.
- mem_write  output  1  to data_mem.
- mem_addr  output  ADDR_W  word-aligned address to data_mem (bits [1:0] = 0).
- mem_wdata  output  XLEN  to data_mem.
- mem_rdata  input  XLEN  combinational read data from data_mem.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- While rst=1, every output is 0, state goes to IDLE, and the internal registers (wr_addr_q, merged_q) clear.
- FSM states:
  - IDLE → RMW_WR on an accepted aligned SB/SH.
  - RMW_WR → IDLE unconditionally.
- Effective request: req_valid=1 and funct3 legal. Illegal funct3 (011, 110, 111) means no strobes, load_data=0, misaligned=0, stall=0.
- Alignment rules:
  - H/HU/SH need addr[0]=0.
  - W/SW need addr[1:0]=00.
  - On violation: misaligned=1 (combinational, same cycle), mem_read=mem_write=0, stall=0, load_data=0. The core traps; the LSU holds no state.
- Load, in IDLE, 0 extra cycles:
  - mem_read=1, mem_addr={addr[31:2],00}.
  - Byte is selected by addr[1:0], half by addr[1]. Little-endian.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- SW, in IDLE: mem_write=1, mem_wdata=req_wdata, stall=0. Completes in one edge.
- SB/SH, cycle 0 (IDLE):
  - mem_read=1, stall=1.
  - merged_q is registered at the edge: mem_rdata with the byte lane(s) at addr[1:0] replaced by req_wdata[7:0] or [15:0].
  - wr_addr_q is registered at the edge.
- SB/SH, cycle 1 (RMW_WR):
  - mem_write=1, mem_addr=wr_addr_q, mem_wdata=merged_q, stall=0.
  - Core inputs are ignored in this state; the core still holds the same request.
  - The core advances at the edge that commits the write.
- Back-to-back sub-word stores: each costs 2 cycles. No overlap; IDLE is revisited each time.
- Reset during RMW_WR: mem_write is forced 0 and the write is abandoned, leaving memory unchanged.
- mem_read and mem_write are never both 1 in the same cycle.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding for IDLE and RMW_WR.
  - Byte-lane mask function.
- One sub-module, lsu_load_ext: purely combinational load lane select and extension, taking mem_rdata, addr[1:0] and funct3, producing load_data.
- Store merge and the FSM stay in lsu_subword.

Test Plan:
1. Preload word 0x10 = 0x112233C4. LW 0x10 → load_data 0x112233C4, stall=0. LB 0x10 → 0xFFFFFFC4. LBU 0x10 → 0x000000C4. LH 0x12 → 0x00001122.
2. SB addr 0x11, wdata 0x000000AB. Cycle0: stall=1, mem_read=1, mem_addr=0x10. Cycle1: mem_write=1, mem_wdata 0x1122ABC4, stall=0. A following LW 0x10 → 0x1122ABC4.
3. SH addr 0x12, wdata 0x0000BEEF on the result of test 2 → cycle1 mem_wdata 0xBEEFABC4. Then SW 0x14 = 0xDEADBEEF → single-cycle mem_write, stall=0, and LW 0x14 → 0xDEADBEEF.
4. Misaligned ops LW 0x06, LH 0x13, SH 0x13 → misaligned=1, mem_read=mem_write=0 in each. LW 0x10 is unchanged afterwards.
5. Two back-to-back SB (0x10 ← 0x55, then 0x13 ← 0x66) → 4 cycles total, stall pattern 1,0,1,0. Final LW 0x10 → 0x66xxxx55 with the middle bytes preserved.
6. Start SB 0x10 ← 0x77, assert rst in the RMW_WR cycle → mem_write=0 and all outputs 0. Next cycle the state is IDLE and LW 0x10 returns the pre-store value.
